// File: rtl/word_store_unit.sv
`default_nettype none
// ============================================================================
// word_store_unit : serializes a 1/2/4-byte store into byte-wide memory writes,
//                   least-significant byte first at the lowest address.
// Revision: 1.0
// ============================================================================
module word_store_unit #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [1:0]            Size,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [31:0]           Data,
    input  logic                  MemReady,
    output logic                  MemWE,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [7:0]            MemData,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [23:0]           r_rest;
    logic [1:0]            r_idx;
    logic [1:0]            r_last;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_maddr;
    logic [7:0]            r_mdata;
    logic                  r_busy;
    logic                  r_done;
    logic [1:0]            w_last;

    // Index of the final byte; the reserved encoding is treated as a word.
    always_comb begin
        w_last = 2'd3;
        case (Size)
            2'b00:   w_last = 2'd0;
            2'b01:   w_last = 2'd1;
            default: w_last = 2'd3;
        endcase
    end

    // MemAddr/MemData double as the running address and current byte, so the
    // remaining bytes live in a shift register that is drained low byte first.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rest  <= '0;
            r_idx   <= '0;
            r_last  <= '0;
            r_we    <= 1'b0;
            r_maddr <= '0;
            r_mdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_state <= S_WRITE;
                        r_rest  <= Data[31:8];
                        r_idx   <= 2'd0;
                        r_last  <= w_last;
                        r_we    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_maddr <= Addr;
                        r_mdata <= Data[7:0];
                    end
                end
                S_WRITE: begin
                    if (MemReady) begin
                        if (r_idx == r_last) begin
                            r_state <= S_DONE;
                            r_we    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_maddr <= r_maddr + ADDR_WIDTH'(1);
                            r_mdata <= r_rest[7:0];
                            r_rest  <= {8'h00, r_rest[23:8]};
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign MemWE   = r_we;
    assign MemAddr = r_maddr;
    assign MemData = r_mdata;
    assign Busy    = r_busy;
    assign Done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_word_store_unit.sv
`default_nettype none
// ============================================================================
// tb_word_store_unit : directed stores checked against a byte-write scoreboard.
// Revision: 1.0
// ============================================================================
module tb_word_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        Start;
    logic [1:0]  Size;
    logic [15:0] Addr;
    logic [31:0] Data;
    logic        MemReady;
    logic        MemWE;
    logic [15:0] MemAddr;
    logic [7:0]  MemData;
    logic        Busy;
    logic        Done;

    word_store_unit #(.ADDR_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .Start(Start), .Size(Size), .Addr(Addr),
        .Data(Data), .MemReady(MemReady), .MemWE(MemWE), .MemAddr(MemAddr),
        .MemData(MemData), .Busy(Busy), .Done(Done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    int   cyc = 0;
    wr_t  expq[$];
    wr_t  wlog[$];
    int   hold_log[$];
    int   hold_cnt = 0;
    int   exp_done = 0;
    int   done_count = 0;
    int   done_cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Every cycle: outputs must agree with the pending expected byte writes.
    always @(negedge clock) begin
        check("busy_eq_we", {31'b0, Busy}, {31'b0, MemWE});
        if (MemWE === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", MemAddr, MemData);
            end else begin
                check("mem_addr", {16'b0, MemAddr}, {16'b0, expq[0].a});
                check("mem_data", {24'b0, MemData}, {24'b0, expq[0].d});
                hold_cnt++;
                if (MemReady === 1'b1 && reset === 1'b0) begin
                    wlog.push_back('{MemAddr, MemData});
                    hold_log.push_back(hold_cnt);
                    hold_cnt = 0;
                    void'(expq.pop_front());
                end
            end
        end
        if (Done === 1'b1) begin
            if (exp_done == 0) begin
                checks++;
                $display("FAIL unexpected_done: got Done=1 expected 0");
            end else begin
                check("done_queue_empty", expq.size(), 0);
                exp_done--;
            end
            done_count++;
            done_cyc = cyc;
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge following Done.
    task automatic store(input logic [1:0] sz, input logic [15:0] a, input logic [31:0] d,
                         input int stall_from, input int stall_n, input bit junk,
                         input int exp_lat, input string nm);
        int  n;
        int  d0;
        int  t;
        int  off;
        bit  got;
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        d0  = done_count;
        got = 1'b0;
        Start = 1'b1; Size = sz; Addr = a; Data = d; MemReady = 1'b1;
        @(posedge clock); #1;
        t = cyc;
        Start = 1'b0; Data = d ^ 32'h5A5A5A5A; Addr = ~a; Size = ~sz;
        wlog.delete(); hold_log.delete(); hold_cnt = 0;
        for (int i = 0; i < n; i++) expq.push_back('{a + 16'(i), d[8*i +: 8]});
        exp_done++;
        for (int k = 0; k < 40; k++) begin
            off = cyc - t;
            MemReady = !(off >= stall_from && off < stall_from + stall_n);
            if (junk && (off == 1 || off == exp_lat)) begin
                Start = 1'b1; Data = 32'hDEADBEEF; Addr = 16'h0BAD; Size = 2'b10;
            end else begin
                Start = 1'b0;
            end
            if (done_count > d0) begin
                got = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        MemReady = 1'b1;
        if (!got) begin
            checks++;
            $display("FAIL %s_timeout: got no Done expected Done within 40 cycles", nm);
        end else begin
            check({nm, "_latency"}, done_cyc - t, exp_lat);
        end
    endtask

    initial begin
        int t;
        int d0;
        logic [15:0] ea [4];
        logic [7:0]  ed [4];
        ea = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
        ed = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

        reset = 1'b1; Start = 1'b0; Size = 2'b00; Addr = '0; Data = '0; MemReady = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_we",    {31'b0, MemWE}, 0);
        check("rst_busy",  {31'b0, Busy}, 0);
        check("rst_done",  {31'b0, Done}, 0);
        check("rst_addr",  {16'b0, MemAddr}, 0);
        check("rst_data",  {24'b0, MemData}, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        store(2'b10, 16'h0100, 32'hA1B2C3D4, 99, 0, 1'b0, 4, "word");
        check("word_nbytes", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            check("word_log_addr", {16'b0, wlog[i].a}, {16'b0, ea[i]});
            check("word_log_data", {24'b0, wlog[i].d}, {24'b0, ed[i]});
        end
        check("idle_hold_we",   {31'b0, MemWE}, 0);
        check("idle_hold_addr", {16'b0, MemAddr}, 32'h0103);
        check("idle_hold_data", {24'b0, MemData}, 32'hA1);

        store(2'b01, 16'h0010, 32'h12345678, 99, 0, 1'b0, 2, "half");
        check("half_nbytes", wlog.size(), 2);
        if (wlog.size() == 2) check("half_byte1", {24'b0, wlog[1].d}, 32'h56);
        store(2'b00, 16'h0020, 32'h000000FF, 99, 0, 1'b0, 1, "byte");
        check("byte_nbytes", wlog.size(), 1);
        if (wlog.size() == 1) check("byte_data", {24'b0, wlog[0].d}, 32'hFF);

        store(2'b10, 16'h0100, 32'hA1B2C3D4, 1, 3, 1'b0, 7, "stall");
        if (hold_log.size() == 4) begin
            check("stall_hold_b0", hold_log[0], 1);
            check("stall_hold_b1", hold_log[1], 4);
        end else check("stall_nbytes", hold_log.size(), 4);

        store(2'b10, 16'hFFFE, 32'hCAFEF00D, 99, 0, 1'b0, 4, "wrap");
        if (wlog.size() == 4) begin
            check("wrap_a1", {16'b0, wlog[1].a}, 32'hFFFF);
            check("wrap_a2", {16'b0, wlog[2].a}, 32'h0000);
            check("wrap_a3", {16'b0, wlog[3].a}, 32'h0001);
        end else check("wrap_nbytes", wlog.size(), 4);

        d0 = done_count;
        store(2'b10, 16'h0040, 32'h01020304, 99, 0, 1'b1, 4, "junk");
        repeat (4) @(posedge clock);
        #1;
        check("junk_one_done", done_count - d0, 1);
        check("junk_nbytes", wlog.size(), 4);

        store(2'b11, 16'h0050, 32'h89ABCDEF, 99, 0, 1'b0, 4, "size11");
        check("size11_nbytes", wlog.size(), 4);

        // Reset mid-transfer, after bytes 0 and 1 have been accepted.
        d0 = done_count;
        wlog.delete();
        Start = 1'b1; Size = 2'b10; Addr = 16'h0200; Data = 32'h11223344; MemReady = 1'b1;
        @(posedge clock); #1;
        t = cyc;
        Start = 1'b0;
        for (int i = 0; i < 4; i++) expq.push_back('{16'h0200 + 16'(i), Data[8*i +: 8]});
        exp_done++;
        @(posedge clock); #1;
        @(posedge clock); #1;
        MemReady = 1'b0; reset = 1'b1;
        @(posedge clock); #1;
        check("mid_rst_we",   {31'b0, MemWE}, 0);
        check("mid_rst_busy", {31'b0, Busy}, 0);
        check("mid_rst_done", {31'b0, Done}, 0);
        check("mid_rst_addr", {16'b0, MemAddr}, 0);
        check("mid_rst_accepted", wlog.size(), 2);
        check("mid_rst_elapsed", cyc - t, 3);
        expq.delete();
        exp_done = 0;
        reset = 1'b0; MemReady = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("mid_rst_no_done", done_count - d0, 0);

        store(2'b10, 16'h0300, 32'h55667788, 99, 0, 1'b0, 4, "fresh");
        if (wlog.size() > 0) begin
            check("fresh_a0", {16'b0, wlog[0].a}, 32'h0300);
            check("fresh_d0", {24'b0, wlog[0].d}, 32'h88);
        end else check("fresh_nbytes", wlog.size(), 4);

        repeat (3) @(posedge clock);
        #1;
        check("final_queue_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
